// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered stream demultiplexer.
// Lane i of a packed lane bus sits at bits [lane_lo(i, dw) +: dw].
package demux_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

    localparam int DEF_N_OUT = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_SEL_W = clog2(DEF_N_OUT);
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux lane.
// The slot is free when empty or draining this cycle, so back-to-back beats flow at full rate.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          free
);

    assign free = !valid || ready;

    // The parent only asserts load while free is high, so unaccepted data is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready input stream to a selected output lane or broadcasts it to all lanes.
// Beats with an out-of-range select are consumed and counted in a saturating drop counter.
module stream_demux
    import demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int DW    = DEF_DW,
    parameter int SEL_W = DEF_SEL_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_bcast,
    output logic [N_OUT-1:0]    out_valid,
    input  logic [N_OUT-1:0]    out_ready,
    output logic [N_OUT*DW-1:0] out_data,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(N_OUT);

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic             sel_ok;
    logic             sel_free;
    logic             all_free;
    logic             fire;

    assign sel_ok   = {1'b0, in_sel} < SEL_LIMIT;
    assign all_free = &free;

    always_comb begin
        sel_free = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_free = free[i];
            end
        end
    end

    // Handshake: a beat transfers on any edge where in_valid && in_ready; in_ready never
    // looks at in_valid, and each lane transfers when out_valid[i] && out_ready[i].
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (in_bcast) begin
                in_ready = all_free;
            end else if (sel_ok) begin
                in_ready = sel_free;
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign fire = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int i = 0; i < N_OUT; i++) begin
            load[i] = fire && (in_bcast || (sel_ok && in_sel == SEL_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (fire && !in_bcast && !sel_ok && drop_cnt != {CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        demux_out_slot #(
            .DW(DW)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[g]),
            .load_data(in_data),
            .ready    (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (out_data[lane_lo(g, DW) +: DW]),
            .free     (free[g])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-lane instance for routing, backpressure, broadcast
// and reset, plus a 3-lane instance for out-of-range select drops and counter saturation.
module tb_stream_demux;

    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_bcast;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic [31:0] a_out_data;
    logic [7:0]  a_drop_cnt;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_bcast;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [23:0] b_out_data;
    logic [7:0]  b_drop_cnt;

    int n_cmp;
    int n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] exp_beat;

    stream_demux #(.N_OUT(4), .DW(8), .SEL_W(2), .CNT_W(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_data  (a_in_data),
        .in_sel   (a_in_sel),
        .in_bcast (a_in_bcast),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .out_data (a_out_data),
        .drop_cnt (a_drop_cnt)
    );

    stream_demux #(.N_OUT(3), .DW(8), .SEL_W(2), .CNT_W(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .in_sel   (b_in_sel),
        .in_bcast (b_in_bcast),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .drop_cnt (b_drop_cnt)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic bc);
        a_in_valid = v;
        a_in_sel   = sel;
        a_in_data  = d;
        a_in_bcast = bc;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] sel, input logic [7:0] d);
        b_in_valid = v;
        b_in_sel   = sel;
        b_in_data  = d;
        b_in_bcast = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        drive_a(1'b1, 2'd0, 8'hFF, 1'b0);
        drive_b(1'b1, 2'd0, 8'hFF);
        a_out_ready = 4'hF;
        b_out_ready = 3'h7;

        // Reset with in_valid high
        settle();
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        tick();
        chk("rst_out_valid", {28'd0, a_out_valid}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_drop_cnt", {24'd0, a_drop_cnt}, 32'd0);
        chk("rst_in_ready_held", {31'd0, a_in_ready}, 32'd0);
        chk("rst_b_drop_cnt", {24'd0, b_drop_cnt}, 32'd0);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        drive_b(1'b0, 2'd0, 8'h00);
        rst = 1'b0;
        settle();
        chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        // Unicast sweep; idle lanes keep their last loaded byte
        drive_a(1'b1, 2'd0, 8'hA5, 1'b0);
        tick();
        chk("uc0_valid", {28'd0, a_out_valid}, 32'h1);
        chk("uc0_data", a_out_data, 32'h000000A5);
        drive_a(1'b1, 2'd1, 8'hA5, 1'b0);
        tick();
        chk("uc1_valid", {28'd0, a_out_valid}, 32'h2);
        chk("uc1_data", a_out_data, 32'h0000A5A5);
        drive_a(1'b1, 2'd2, 8'hA5, 1'b0);
        tick();
        chk("uc2_valid", {28'd0, a_out_valid}, 32'h4);
        chk("uc2_data", a_out_data, 32'h00A5A5A5);
        drive_a(1'b1, 2'd3, 8'hA5, 1'b0);
        tick();
        chk("uc3_valid", {28'd0, a_out_valid}, 32'h8);
        chk("uc3_data", a_out_data, 32'hA5A5A5A5);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("uc_idle_valid", {28'd0, a_out_valid}, 32'h0);

        // Backpressure on lane 2
        a_out_ready = 4'b1011;
        drive_a(1'b1, 2'd2, 8'h11, 1'b0);
        exp_q.push_back(8'h11);
        settle();
        chk("bp_ready_first", {31'd0, a_in_ready}, 32'd1);
        tick();
        chk("bp_valid_first", {28'd0, a_out_valid}, 32'h4);
        exp_beat = exp_q.pop_front();
        chk("bp_lane2_first", {24'd0, a_out_data[23:16]}, {24'd0, exp_beat});
        drive_a(1'b1, 2'd2, 8'h22, 1'b0);
        settle();
        chk("bp_ready_blocked", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk("bp_hold_valid", {28'd0, a_out_valid}, 32'h4);
        chk("bp_hold_data", {24'd0, a_out_data[23:16]}, 32'h11);
        drive_a(1'b1, 2'd1, 8'h77, 1'b0);
        settle();
        chk("bp_other_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        chk("bp_other_valid", {28'd0, a_out_valid}, 32'h6);
        chk("bp_other_data", {24'd0, a_out_data[15:8]}, 32'h77);
        a_out_ready = 4'hF;
        drive_a(1'b1, 2'd2, 8'h22, 1'b0);
        exp_q.push_back(8'h22);
        settle();
        chk("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        chk("bp_release_valid", {28'd0, a_out_valid}, 32'h4);
        exp_beat = exp_q.pop_front();
        chk("bp_lane2_second", {24'd0, a_out_data[23:16]}, {24'd0, exp_beat});
        chk("bp_release_data", a_out_data, 32'hA52277A5);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("bp_drained", {28'd0, a_out_valid}, 32'h0);

        // Broadcast against a stalled lane
        a_out_ready = 4'b1011;
        drive_a(1'b1, 2'd2, 8'h55, 1'b0);
        tick();
        chk("bc_fill_valid", {28'd0, a_out_valid}, 32'h4);
        drive_a(1'b1, 2'd1, 8'h3C, 1'b1);
        settle();
        chk("bc_ready_blocked", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk("bc_no_partial_valid", {28'd0, a_out_valid}, 32'h4);
        chk("bc_no_partial_data", a_out_data, 32'hA55577A5);
        a_out_ready = 4'hF;
        settle();
        chk("bc_ready_open", {31'd0, a_in_ready}, 32'd1);
        tick();
        chk("bc_valid_all", {28'd0, a_out_valid}, 32'hF);
        chk("bc_data_all", a_out_data, 32'h3C3C3C3C);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("bc_drained", {28'd0, a_out_valid}, 32'h0);

        // Out-of-range select on the 3-lane instance
        b_out_ready = 3'b000;
        drive_b(1'b1, 2'd1, 8'h42);
        tick();
        chk("inv_fill_valid", {29'd0, b_out_valid}, 32'h2);
        drive_b(1'b1, 2'd3, 8'h99);
        settle();
        chk("inv_in_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        chk("inv_valid_same", {29'd0, b_out_valid}, 32'h2);
        chk("inv_data_same", {8'd0, b_out_data}, 32'h004200);
        chk("inv_drop_1", {24'd0, b_drop_cnt}, 32'd1);
        repeat (253) tick();
        chk("inv_drop_254", {24'd0, b_drop_cnt}, 32'd254);
        tick();
        chk("inv_drop_255", {24'd0, b_drop_cnt}, 32'd255);
        repeat (45) tick();
        chk("inv_drop_sat", {24'd0, b_drop_cnt}, 32'd255);
        chk("inv_a_drop_zero", {24'd0, a_drop_cnt}, 32'd0);
        drive_b(1'b0, 2'd0, 8'h00);
        b_out_ready = 3'h7;
        tick();

        // Reset mid-operation with lanes 0 and 3 stalled
        a_out_ready = 4'b0110;
        drive_a(1'b1, 2'd0, 8'h0A, 1'b0);
        tick();
        drive_a(1'b1, 2'd3, 8'h0D, 1'b0);
        tick();
        chk("mid_valid", {28'd0, a_out_valid}, 32'h9);
        chk("mid_data", a_out_data, 32'h0D3C3C0A);
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {28'd0, a_out_valid}, 32'h0);
        chk("mid_rst_data", a_out_data, 32'd0);
        chk("mid_rst_b_drop", {24'd0, b_drop_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_no_stale", {28'd0, a_out_valid}, 32'h0);
        a_out_ready = 4'hF;
        tick();
        chk("mid_still_idle", {28'd0, a_out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
